gru_ht_update: RTL and testbench

//  Forward-path GRU hidden-state update, one element per transaction:
//  ht = (1 - zt)*htb + zt*hc, Q2.14 signed fixed point (+1.0 = 16'h4000).

---
 rtl/gru_ht_update.sv | 109 ++++++++++
 tb/tb_gru_ht_update.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/gru_ht_update.sv
// rtl/gru_ht_update.sv - GRU hidden-state update ht = (1-zt)*htb + zt*hc, Q2.14, one shared multiplier.
// Five-state FSM with registered handshake; counts elements to flag the last of each vector.
module gru_ht_update #(
  parameter int DATABIT = 16,
  parameter int FRAC    = 14,
  parameter int N       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATABIT-1:0] zt,
  input  logic signed [DATABIT-1:0] htb,
  input  logic signed [DATABIT-1:0] hc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATABIT-1:0] ht,
  output logic                      out_last
);

  localparam int PW  = 2 * DATABIT + 1;
  localparam int PSW = PW - FRAC;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [DATABIT:0]   ONE   = {{(DATABIT-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [DATABIT:0]   P_MAX = {1'b0, {DATABIT{1'b1}}};
  localparam logic signed [DATABIT:0]   P_MIN = {1'b1, {DATABIT{1'b0}}};
  localparam logic signed [DATABIT-1:0] H_MAX = {1'b0, {(DATABIT-1){1'b1}}};
  localparam logic signed [DATABIT-1:0] H_MIN = {1'b1, {(DATABIT-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, SUM, OUT} state_t;

  state_t                    state;
  logic signed [DATABIT-1:0] zt_q, htb_q, hc_q;
  logic signed [DATABIT:0]   p1, p2;
  logic [IW-1:0]             idx;

  logic signed [DATABIT:0]   omz, mul_a;
  logic signed [DATABIT-1:0] mul_b;
  logic signed [PW-1:0]      ext_a, ext_b;
  logic signed [PSW-1:0]     prod_sh;
  logic signed [DATABIT:0]   prod_sat;
  logic signed [DATABIT+1:0] sum;
  logic signed [DATABIT-1:0] sum_sat;
  logic                      prod_fits, sum_fits;

  // 17-bit omz keeps zt = -1.0 from wrapping to a negative weight.
  always_comb begin
    omz      = ONE - {zt_q[DATABIT-1], zt_q};
    mul_a    = (state == MUL_A) ? omz : {zt_q[DATABIT-1], zt_q};
    mul_b    = (state == MUL_A) ? htb_q : hc_q;
    ext_a    = {{(PW-DATABIT-1){mul_a[DATABIT]}}, mul_a};
    ext_b    = {{(PW-DATABIT){mul_b[DATABIT-1]}}, mul_b};
    prod_sh  = PSW'((ext_a * ext_b) >>> FRAC);
    prod_fits = (&prod_sh[PSW-1:DATABIT]) | ~(|prod_sh[PSW-1:DATABIT]);
    prod_sat = prod_fits ? prod_sh[DATABIT:0] : (prod_sh[PSW-1] ? P_MIN : P_MAX);
    sum      = {p1[DATABIT], p1} + {p2[DATABIT], p2};
    sum_fits = (&sum[DATABIT+1:DATABIT-1]) | ~(|sum[DATABIT+1:DATABIT-1]);
    sum_sat  = sum_fits ? sum[DATABIT-1:0] : (sum[DATABIT+1] ? H_MIN : H_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ht        <= '0;
      idx       <= '0;
      zt_q      <= '0;
      htb_q     <= '0;
      hc_q      <= '0;
      p1        <= '0;
      p2        <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          zt_q     <= zt;
          htb_q    <= htb;
          hc_q     <= hc;
          in_ready <= 1'b0;
          state    <= MUL_A;
        end
        MUL_A: begin
          p1    <= prod_sat;
          state <= MUL_B;
        end
        MUL_B: begin
          p2    <= prod_sat;
          state <= SUM;
        end
        SUM: begin
          ht        <= sum_sat;
          out_valid <= 1'b1;
          out_last  <= (idx == IW'(N - 1));
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          idx       <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gru_ht_update.sv
// tb/tb_gru_ht_update.sv - randomized self-checking bench for gru_ht_update against an arithmetic model.
module tb_gru_ht_update;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [15:0] zt, htb, hc, ht;
  int          errors = 0;
  int          checks = 0;
  int          tb_idx = 0;

  always #5 clk = ~clk;

  gru_ht_update #(.DATABIT(16), .FRAC(14), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .zt(zt), .htb(htb), .hc(hc), .out_valid(out_valid), .out_ready(out_ready),
    .ht(ht), .out_last(out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [15:0] model(input logic [15:0] z, input logic [15:0] h, input logic [15:0] c);
    longint zi, hi, ci, p1, p2, s;
    zi = longint'($signed(z));
    hi = longint'($signed(h));
    ci = longint'($signed(c));
    p1 = clamp(((16384 - zi) * hi) >>> 14, -65536, 65535);
    p2 = clamp((zi * ci) >>> 14, -65536, 65535);
    s  = clamp(p1 + p2, -32768, 32767);
    return s[15:0];
  endfunction

  task automatic run_elem(input logic [15:0] z, input logic [15:0] h, input logic [15:0] c, input int hold);
    logic [15:0] exp;
    logic        exp_last;
    int          n;
    exp      = model(z, h, c);
    exp_last = (tb_idx == N - 1);
    zt = z; htb = h; hc = c;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    zt = 16'($urandom); htb = 16'($urandom); hc = 16'($urandom);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("busy_valid", out_valid, 0);
      check("busy_ready", in_ready, 0);
    end
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("ht", ht, exp);
    check("out_last", out_last, exp_last);
    check("out_in_ready", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_ht", ht, exp);
      check("hold_last", out_last, exp_last);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("done_valid", out_valid, 0);
    check("done_ready", in_ready, 1);
    tb_idx = (tb_idx + 1) % N;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    zt = '0; htb = '0; hc = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_ht", ht, 0);
    check("rst_out_last", out_last, 0);
    rst = 1'b0;
    @(negedge clk);

    run_elem(16'h2000, 16'h4000, 16'h0000, 0);
    check("t1_value", ht, 16'h2000);
    run_elem(16'h4000, 16'h1234, 16'hC000, 0);
    check("t2_value", ht, 16'hC000);
    run_elem(16'hC000, 16'h6000, 16'h0000, 0);
    check("t3_value", ht, 16'h7FFF);
    run_elem(16'h1000, 16'h2000, 16'hE000, 6);

    for (int i = 0; i < 6; i++)
      run_elem(16'h2000, 16'(16'h0100 + i * 16'h0400), 16'h1800, 0);

    // Abort during MUL_B with idx at 2; counter must restart from 0.
    check("t6_idx_before", tb_idx, 2);
    zt = 16'h3000; htb = 16'h1000; hc = 16'h2000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_ht", ht, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_out_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    tb_idx = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      run_elem(16'($urandom), 16'($urandom), 16'($urandom), 0);

    for (int i = 0; i < 40; i++)
      run_elem(16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1);
  end
endmodule
